// File: rtl/mul_share_arbiter_pkg.sv
// Shared types for the multiplier-sharing arbiter: element, byte-strobe and
// operation types plus the arbiter's lock state encoding.
package mul_share_arbiter_pkg;

  localparam int unsigned ELEN  = 64;
  localparam int unsigned ELENB = ELEN / 8;

  typedef logic [ELEN-1:0]  elen_t;
  typedef logic [ELENB-1:0] strb_t;

  typedef enum logic [2:0] {
    VMUL, VMULH, VMULHU, VMULHSU, VMACC, VNMSAC, VMADD, VNMSUB
  } ara_op_e;

  // ARB_LOCKED: a stalled grant is pinned until its request handshakes.
  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/mul_share_arbiter_fifo.sv
// In-order tag FIFO (registered head, no fall-through). Push into a full
// FIFO is legal when a pop happens in the same cycle.
module mul_share_arbiter_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  usage_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;

  function automatic logic [AddrW-1:0] bump(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= bump(wr_ptr);
      if (pop_i)  rd_ptr <= bump(rd_ptr);
      if (push_i && !pop_i)      count <= count + CntW'(1);
      else if (pop_i && !push_i) count <= count - CntW'(1);
    end
  end

  assign data_o  = mem[rd_ptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == CntW'(DEPTH));
  assign usage_o = count;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier among NumReq requesters: locking round-robin issue,
// in-order tag FIFO, and result routing back to the issuing requester.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxInflight = 2,
  localparam int unsigned TagW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW = $clog2(MaxInflight + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic     [NumReq-1:0]  req_valid_i,
  output logic     [NumReq-1:0]  req_ready_o,
  input  elen_t    [NumReq-1:0]  req_operand_a_i,
  input  elen_t    [NumReq-1:0]  req_operand_b_i,
  input  elen_t    [NumReq-1:0]  req_operand_c_i,
  input  ara_op_e  [NumReq-1:0]  req_op_i,
  input  strb_t    [NumReq-1:0]  req_mask_i,
  output elen_t                  mul_operand_a_o,
  output elen_t                  mul_operand_b_o,
  output elen_t                  mul_operand_c_o,
  output ara_op_e                mul_op_o,
  output strb_t                  mul_mask_o,
  output logic                   mul_valid_o,
  input  logic                   mul_ready_i,
  input  elen_t                  mul_result_i,
  input  strb_t                  mul_mask_i,
  input  logic                   mul_valid_i,
  output logic                   mul_ready_o,
  output elen_t                  rsp_result_o,
  output strb_t                  rsp_mask_o,
  output logic     [NumReq-1:0]  rsp_valid_o,
  input  logic     [NumReq-1:0]  rsp_ready_i,
  output logic     [CntW-1:0]    inflight_o,
  output arb_state_e             arb_state_o
);

  localparam type tag_t = logic [TagW-1:0];

  arb_state_e state_q, state_d;
  tag_t rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
  tag_t rr_pick, winner, tag;
  logic any_req, issue_ok, issue, pop, fifo_empty, fifo_full;

  // Every channel uses valid/ready: a transfer happens in the cycle both are
  // high; valid never waits on ready, and a raised valid holds its payload.
  assign any_req = |req_valid_i;

  always_comb begin : rr_search
    int cand;
    rr_pick = rr_ptr_q;
    // Descending scan: the lowest offset from rr_ptr_q is written last and wins.
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      cand = (int'(rr_ptr_q) + i) % int'(NumReq);
      if (req_valid_i[tag_t'(cand)]) rr_pick = tag_t'(cand);
    end
  end

  assign winner      = (state_q == ARB_LOCKED) ? lock_idx_q : rr_pick;
  assign issue_ok    = !fifo_full || pop;
  assign mul_valid_o = rst_ni && any_req && issue_ok;
  assign issue       = mul_valid_o && mul_ready_i;

  assign mul_operand_a_o = req_operand_a_i[winner];
  assign mul_operand_b_o = req_operand_b_i[winner];
  assign mul_operand_c_o = req_operand_c_i[winner];
  assign mul_op_o        = req_op_i[winner];
  assign mul_mask_o      = req_mask_i[winner];

  always_comb begin : grant_ready
    req_ready_o         = '0;
    req_ready_o[winner] = issue;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
    if (!rst_ni) begin
      state_q    <= ARB_OPEN;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      ARB_OPEN:   if (mul_valid_o && !mul_ready_i) state_d = ARB_LOCKED;
      ARB_LOCKED: if (issue) state_d = ARB_OPEN;
      default:    state_d = ARB_OPEN;
    endcase
  end

  always_comb begin : arb_outputs
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    arb_state_o = state_q;
    if (issue) rr_ptr_d = (winner == tag_t'(NumReq - 1)) ? '0 : winner + tag_t'(1);
    if (state_q == ARB_OPEN && mul_valid_o && !mul_ready_i) lock_idx_d = rr_pick;
  end

  mul_share_arbiter_fifo #(
    .DEPTH (MaxInflight),
    .WIDTH (TagW)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (issue),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (tag),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .usage_o (inflight_o)
  );

  // In-order return: the FIFO head names the requester owning this result.
  assign mul_ready_o  = !fifo_empty && rsp_ready_i[tag];
  assign pop          = mul_valid_i && mul_ready_o;
  assign rsp_result_o = mul_result_i;
  assign rsp_mask_o   = mul_mask_i;

  always_comb begin : rsp_route
    rsp_valid_o      = '0;
    rsp_valid_o[tag] = mul_valid_i && !fifo_empty;
  end

  result_without_tag: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(mul_valid_i && fifo_empty));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model and multiplier stub.
module tb_mul_share_arbiter;
  import mul_share_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int MI = 2;
  localparam int CW = $clog2(MI + 1);

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  logic    [NR-1:0] req_valid_i = '0;
  logic    [NR-1:0] req_ready_o;
  elen_t   [NR-1:0] req_a = '0, req_b = '0, req_c = '0;
  ara_op_e [NR-1:0] req_op = {NR{VMUL}};
  strb_t   [NR-1:0] req_mask = '0;
  elen_t   mul_operand_a_o, mul_operand_b_o, mul_operand_c_o;
  ara_op_e mul_op_o;
  strb_t   mul_mask_o;
  logic    mul_valid_o;
  logic    mul_ready_i = 1'b0;
  elen_t   mul_result_i = '0;
  strb_t   mul_mask_i = '0;
  logic    mul_valid_i = 1'b0;
  logic    mul_ready_o;
  elen_t   rsp_result_o;
  strb_t   rsp_mask_o;
  logic    [NR-1:0] rsp_valid_o;
  logic    [NR-1:0] rsp_ready_i = '0;
  logic    [CW-1:0] inflight_o;
  arb_state_e arb_state_o;

  mul_share_arbiter #(.NumReq(NR), .MaxInflight(MI)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operand_a_i(req_a), .req_operand_b_i(req_b), .req_operand_c_i(req_c),
    .req_op_i(req_op), .req_mask_i(req_mask),
    .mul_operand_a_o(mul_operand_a_o), .mul_operand_b_o(mul_operand_b_o),
    .mul_operand_c_o(mul_operand_c_o), .mul_op_o(mul_op_o), .mul_mask_o(mul_mask_o),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i),
    .mul_result_i(mul_result_i), .mul_mask_i(mul_mask_i),
    .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o),
    .rsp_result_o(rsp_result_o), .rsp_mask_o(rsp_mask_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .inflight_o(inflight_o), .arb_state_o(arb_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: arbitration pointer, pending lock, expected tag order
  int rr_m = 0;
  int lock_m = -1;
  int tag_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  exp_mask_q[$];

  // Multiplier stub (one pipeline register): results queue in issue order
  elen_t mq_res[$];
  strb_t mq_mask[$];
  bit stub_stall = 0;

  // Values captured at the sample point, consumed at the next edge
  bit s_iss, s_pop, s_lock_req, s_act_iss, s_act_pop;
  int s_win;
  elen_t s_ma, s_mb;
  strb_t s_mm;
  logic [NR-1:0] s_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Settle inputs, compare against the model, capture handshake decisions.
  task automatic sample();
    int n, win;
    bit any_v, pop, mv, mr;
    logic [NR-1:0] one, rdy, rv;
    #3;
    one = 1;
    n = tag_q.size();
    any_v = |req_valid_i;
    win = rr_m;
    if (lock_m >= 0) win = lock_m;
    else begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid_i[(rr_m + i) % NR]) begin
          win = (rr_m + i) % NR;
          break;
        end
      end
    end
    mr  = (n > 0) ? rsp_ready_i[tag_q[0]] : 1'b0;
    pop = mul_valid_i && mr;
    mv  = any_v && (n < MI || pop);
    rdy = (mv && mul_ready_i) ? (one << win) : '0;
    rv  = (n > 0 && mul_valid_i) ? (one << tag_q[0]) : '0;
    check("mul_valid", 64'(mul_valid_o), 64'(mv));
    check("req_ready", 64'(req_ready_o), 64'(rdy));
    check("rsp_valid", 64'(rsp_valid_o), 64'(rv));
    check("mul_ready", 64'(mul_ready_o), 64'(mr));
    check("inflight", 64'(inflight_o), 64'(n));
    if (mv) begin
      check("mul_operand_a", mul_operand_a_o, req_a[win]);
      check("mul_operand_b", mul_operand_b_o, req_b[win]);
      check("mul_mask", 64'(mul_mask_o), 64'(req_mask[win]));
    end
    if (pop) begin
      check("rsp_result", rsp_result_o, exp_q[0]);
      check("rsp_mask", 64'(rsp_mask_o), 64'(exp_mask_q[0]));
    end
    s_iss = mv && mul_ready_i;
    s_pop = pop;
    s_lock_req = mv && !mul_ready_i;
    s_win = win;
    s_act_iss = mul_valid_o && mul_ready_i;
    s_act_pop = mul_valid_i && mul_ready_o;
    s_ma = mul_operand_a_o;
    s_mb = mul_operand_b_o;
    s_mm = mul_mask_o;
    s_acc = req_ready_o;
  endtask

  // Clock edge: advance model and stub, then drive the stub's result port.
  task automatic tick();
    @(posedge clk_i);
    if (s_pop) begin
      void'(tag_q.pop_front());
      void'(exp_q.pop_front());
      void'(exp_mask_q.pop_front());
    end
    if (s_iss) begin
      tag_q.push_back(s_win);
      exp_q.push_back(req_a[s_win] * req_b[s_win]);
      exp_mask_q.push_back(req_mask[s_win]);
      rr_m = (s_win + 1) % NR;
      lock_m = -1;
    end else if (s_lock_req && lock_m < 0) begin
      lock_m = s_win;
    end
    if (s_act_pop && mq_res.size() > 0) begin
      void'(mq_res.pop_front());
      void'(mq_mask.pop_front());
    end
    if (s_act_iss) begin
      mq_res.push_back(s_ma * s_mb);
      mq_mask.push_back(s_mm);
    end
    #1;
    mul_valid_i  = (mq_res.size() > 0) && !stub_stall;
    mul_result_i = (mq_res.size() > 0) ? mq_res[0] : '0;
    mul_mask_i   = (mq_mask.size() > 0) ? mq_mask[0] : '0;
  endtask

  // Driver: one directed cycle
  task automatic drive(input logic [NR-1:0] v, input logic mr, input logic [NR-1:0] rr);
    req_valid_i = v;
    mul_ready_i = mr;
    rsp_ready_i = rr;
  endtask

  task automatic set_payload(input int k);
    req_a[k]    = {$urandom, $urandom};
    req_b[k]    = {$urandom, $urandom};
    req_c[k]    = {$urandom, $urandom};
    req_mask[k] = strb_t'($urandom);
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          mready;
    logic [NR-1:0] rready;
    logic [NR-1:0] e_rdy;
    logic [NR-1:0] e_rsp;
    logic          e_mv;
    int            e_inf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Fairness (grants 0,1,0,1,0,1) then a lone request from requester 0.
    tbl[0] = '{2'b11, 1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 0};
    tbl[1] = '{2'b11, 1'b1, 2'b11, 2'b10, 2'b01, 1'b1, 1};
    tbl[2] = '{2'b11, 1'b1, 2'b11, 2'b01, 2'b10, 1'b1, 1};
    tbl[3] = '{2'b11, 1'b1, 2'b11, 2'b10, 2'b01, 1'b1, 1};
    tbl[4] = '{2'b11, 1'b1, 2'b11, 2'b01, 2'b10, 1'b1, 1};
    tbl[5] = '{2'b11, 1'b1, 2'b11, 2'b10, 2'b01, 1'b1, 1};
    tbl[6] = '{2'b01, 1'b1, 2'b11, 2'b01, 2'b10, 1'b1, 1};
    tbl[7] = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b01, 1'b0, 1};
    tbl[8] = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 0};

    req_a[0] = 64'd3; req_b[0] = 64'd5; req_mask[0] = 8'hff;
    req_a[1] = 64'd7; req_b[1] = 64'd9; req_mask[1] = 8'h0f;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_inflight", 64'(inflight_o), 64'd0);
    check("reset_mul_valid", 64'(mul_valid_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_arb_state", 64'(arb_state_o), 64'(ARB_OPEN));
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].valid, tbl[i].mready, tbl[i].rready);
      sample();
      check($sformatf("tbl%0d_req_ready", i), 64'(req_ready_o), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_rsp_valid", i), 64'(rsp_valid_o), 64'(tbl[i].e_rsp));
      check($sformatf("tbl%0d_mul_valid", i), 64'(mul_valid_o), 64'(tbl[i].e_mv));
      check($sformatf("tbl%0d_inflight", i), 64'(inflight_o), 64'(tbl[i].e_inf));
      if (i == 7) check("single_result", rsp_result_o, 64'd15);
      tick();
    end

    // Lock: move pointer to 0, stall requester 1 while requester 0 arrives.
    drive(2'b10, 1'b1, 2'b11); sample(); tick();
    drive(2'b10, 1'b0, 2'b11); sample(); tick();
    drive(2'b11, 1'b0, 2'b11); sample();
    check("lock_held_operand", mul_operand_a_o, 64'd7);
    check("lock_state", 64'(arb_state_o), 64'(ARB_LOCKED));
    tick();
    drive(2'b11, 1'b0, 2'b11); sample(); tick();
    drive(2'b11, 1'b1, 2'b11); sample();
    check("lock_issue_first", 64'(req_ready_o), 64'(2'b10));
    tick();
    drive(2'b01, 1'b1, 2'b11); sample();
    check("lock_then_req0", 64'(req_ready_o), 64'(2'b01));
    tick();
    repeat (2) begin drive(2'b00, 1'b1, 2'b11); sample(); tick(); end

    // Full FIFO, then simultaneous pop and issue.
    repeat (2) begin drive(2'b11, 1'b1, 2'b00); sample(); tick(); end
    drive(2'b11, 1'b1, 2'b00); sample();
    check("full_inflight", 64'(inflight_o), 64'd2);
    check("full_mul_valid", 64'(mul_valid_o), 64'd0);
    tick();
    drive(2'b11, 1'b1, 2'b11); sample();
    check("full_pop_issue", 64'(mul_valid_o & mul_ready_o), 64'd1);
    tick();
    drive(2'b00, 1'b1, 2'b11); sample();
    check("full_inflight_kept", 64'(inflight_o), 64'd2);
    tick();
    repeat (2) begin drive(2'b00, 1'b1, 2'b11); sample(); tick(); end

    // Head-of-line: tag 0 then 1, requester 0 not ready.
    drive(2'b01, 1'b1, 2'b10); sample(); tick();
    drive(2'b10, 1'b1, 2'b10); sample(); tick();
    drive(2'b00, 1'b1, 2'b10); sample();
    check("hol_mul_ready", 64'(mul_ready_o), 64'd0);
    check("hol_rsp_valid", 64'(rsp_valid_o), 64'(2'b01));
    check("hol_inflight", 64'(inflight_o), 64'd2);
    tick();
    drive(2'b00, 1'b1, 2'b11); sample();
    check("hol_first", 64'(rsp_valid_o), 64'(2'b01));
    tick();
    drive(2'b00, 1'b1, 2'b11); sample();
    check("hol_second", 64'(rsp_valid_o), 64'(2'b10));
    tick();

    // Asynchronous reset with two results in flight.
    repeat (2) begin drive(2'b11, 1'b1, 2'b00); sample(); tick(); end
    drive(2'b11, 1'b1, 2'b00); sample();
    rst_ni = 1'b0;
    mq_res.delete(); mq_mask.delete();
    mul_valid_i = 1'b0;
    #1;
    check("arst_mul_valid", 64'(mul_valid_o), 64'd0);
    check("arst_req_ready", 64'(req_ready_o), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("arst_inflight", 64'(inflight_o), 64'd0);
    check("arst_state", 64'(arb_state_o), 64'(ARB_OPEN));
    rr_m = 0; lock_m = -1;
    tag_q.delete(); exp_q.delete(); exp_mask_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(2'b11, 1'b1, 2'b11); sample();
    check("arst_first_grant", 64'(req_ready_o), 64'(2'b01));
    tick();

    // Randomized traffic: requesters hold valid and payload until accepted.
    for (int k = 0; k < NR; k++) set_payload(k);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (s_acc[k] || !req_valid_i[k]) begin
          req_valid_i[k] = ($urandom_range(0, 2) != 0);
          set_payload(k);
        end
      end
      mul_ready_i = ($urandom_range(0, 3) != 0);
      rsp_ready_i = NR'($urandom_range(0, 3));
      stub_stall  = ($urandom_range(0, 4) == 0);
      sample();
      tick();
    end

    // Drain with a bounded cycle budget.
    stub_stall = 0;
    for (int c = 0; c < 20 && tag_q.size() > 0; c++) begin
      drive('0, 1'b1, '1);
      sample();
      tick();
    end
    check("drain_empty", 64'(tag_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one `simd_mul` instance among `NumReq` requesters within a lane. Arbitrates issue with a locking round-robin scheme and records the winner's index in an in-order tag FIFO. Routes each multiplier result back to the requester that issued it. Sits between the lane's vector functional-unit sequencers and the multiplier's valid/ready operand and result ports.

## Interface
- `NumReq`, 2: number of requesters; must be ≥ 2.
- `MaxInflight`, 2: tag FIFO depth; set to the multiplier's `NumPipeRegs + 1`; must be ≥ 1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in `NumReq`: per-requester operand valid.
- `req_ready_o` out `NumReq`: per-requester operand accept.
- `req_operand_a_i`, `req_operand_b_i`, `req_operand_c_i` in `NumReq`×`elen_t`: operands.
- `req_op_i` in `NumReq`×`ara_op_e`: multiplier operation.
- `req_mask_i` in `NumReq`×`strb_t`: byte mask.
- `mul_operand_a_o`, `mul_operand_b_o`, `mul_operand_c_o` out `elen_t`: operands to the multiplier.
- `mul_op_o` out `ara_op_e`; `mul_mask_o` out `strb_t`; `mul_valid_o` out 1; `mul_ready_i` in 1.
- `mul_result_i` in `elen_t`; `mul_mask_i` in `strb_t`; `mul_valid_i` in 1; `mul_ready_o` out 1.
- `rsp_result_o` out `elen_t`; `rsp_mask_o` out `strb_t`: shared by all requesters.
- `rsp_valid_o` out `NumReq`: one-hot response valid.
- `rsp_ready_i` in `NumReq`.
- `inflight_o` out `$clog2(MaxInflight+1)`: number of occupied tag FIFO entries.

## Operation
- **Reset values.** The round-robin pointer, lock flag and locked index reset to 0. The FIFO is empty and `inflight_o`=0. All valid outputs are 0.
- **Eligibility.** `issue_ok` = (`inflight` < `MaxInflight`) OR (a result is popped this cycle).
- **Arbitration, unlocked.**
  - The winner is the first requester with `req_valid_i` set, searching from `rr_ptr` upward with wrap-around.
  - The winner's payload drives the `mul_*` outputs.
  - `mul_valid_o` = (any request) AND `issue_ok`.
- **Lock.** If `mul_valid_o`=1 and `mul_ready_i`=0, the arbiter locks onto the winner. The grant is then held until that request handshakes. Requesters must not drop valid or change payload while it is pending.
- **Issue handshake.** Issue happens when `mul_valid_o` and `mul_ready_i` are both 1. On issue:
  - `req_ready_o[winner]`=1; all other `req_ready_o` bits are 0.
  - The winner index is pushed into the FIFO.
  - `rr_ptr` becomes winner+1 modulo `NumReq`.
  - The lock clears.
- **Return path.**
  - `tag` is the FIFO head.
  - `rsp_valid_o[tag]` = `mul_valid_i`; all other `rsp_valid_o` bits are 0.
  - `rsp_result_o` and `rsp_mask_o` pass straight through from the multiplier.
  - `mul_ready_o` = `rsp_ready_i[tag]`.
  - Pop happens when `mul_valid_i` and `mul_ready_o` are both 1.
- **Head-of-line.** A stalled responder stalls every later result. This is intended, because the multiplier is in-order.
- **Full FIFO with simultaneous pop.** Issue is still allowed; `inflight` is unchanged.
- **Empty FIFO.** `mul_valid_i`=1 while the FIFO is empty is a protocol error: assert it. `mul_ready_o`=0 in that case.
- **Counter update.** `inflight` +1 on push only, −1 on pop only, unchanged on both or neither.
- **Reset mid-operation.** All state clears immediately and outputs return to their reset values. Results that were in flight are orphaned; the integrator must reset the multiplier together with this block.

## Timing
- Issue path is combinational: `req_*` → `mul_*`, zero latency.
- Return path is combinational: `mul_result_i` → `rsp_*`, zero latency.
- Pointer, lock and FIFO update on the clock edge after a handshake.
- Combinational path `rsp_ready_i` → `mul_ready_o` → (pop) → `mul_valid_o`. This path is allowed; there is no path from `mul_ready_i` to `mul_valid_o`.
- Throughput is one issue and one return per cycle when `MaxInflight` ≥ pipeline depth + 1.

## Structure
- Reuse the `ara_pkg` types `elen_t` and `ara_op_e`. Add `strb_t` to `ara_pkg` if it is not already global.
- Tag type: `logic [$clog2(NumReq)-1:0]`, declared as a localparam type in the module.
- Sub-module: use the common-cells `fifo_v3` for the tag FIFO (`DEPTH`=`MaxInflight`, `FALL_THROUGH`=0). Round-robin selection is inline RTL.

## Test plan
- **Single requester.** `NumReq`=2, `MaxInflight`=2, `NumPipeRegs`=1. Requester 0 sends VMUL 3×5 → one cycle after issue, `rsp_valid_o`=2'b01 and `rsp_result_o`=15.
- **Fairness.** Both requesters hold valid for 6 cycles with `mul_ready_i`=1 → grants alternate 0,1,0,1,0,1. Responses return in the same order, each on its own `rsp_valid_o` bit.
- **Lock.** Requester 1 wins while `mul_ready_i`=0 for 3 cycles; requester 0 raises valid during the stall → the grant stays on 1 and issues first, then requester 0 issues.
- **Full FIFO.** With `rsp_ready_i`=0, issue 2 ops → `inflight_o`=2 and `mul_valid_o`=0. Raise `rsp_ready_i` → a pop and an issue occur in the same cycle and `inflight_o` stays at 2.
- **Head-of-line.** Tags in order 0 then 1; `rsp_ready_i[0]`=0 → `mul_ready_o`=0 and requester 1's result waits. Release → results come out 0 then 1.
- **Async reset.** Assert `rst_ni` mid-stream with `inflight_o`=2 → all valid outputs and `inflight_o` read 0 without a clock edge, and the first grant after reset goes to requester 0.
